// File: rtl/ir_decoder_nec.sv
// NEC infrared frame decoder: input synchroniser, glitch filter, edge-interval
// classifier, frame FSM and a valid/ack holding register for decoded payloads.
module ir_decoder_nec #(
   parameter int NBITS     = 32,
   parameter int CNT_W     = 21,
   parameter int FILT_LEN  = 4,
   parameter int INVERT    = 0,
   parameter int CHECK_INV = 1,
   parameter int T0_MIN    = 25312,
   parameter int T0_MAX    = 30937,
   parameter int T1_MIN    = 50000,
   parameter int T1_MAX    = 61875,
   parameter int START_MIN = 310000,
   parameter int START_MAX = 360000,
   parameter int REP_MIN   = 255000,
   parameter int REP_MAX   = 300000,
   parameter int TIMEOUT   = 1750000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             ir_in,
   input  logic             cmd_ack,
   output logic             cmd_valid,
   output logic [NBITS-1:0] cmd_data,
   output logic             cmd_repeat,
   output logic             err_pulse,
   output logic [1:0]       err_code,
   output logic             overrun,
   output logic             busy
);
   localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int FC_W  = $clog2(FILT_LEN + 1);
   localparam logic INV_B = (INVERT != 0);
   localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] T0_LO  = CNT_W'(T0_MIN);
   localparam logic [CNT_W-1:0] T0_HI  = CNT_W'(T0_MAX);
   localparam logic [CNT_W-1:0] T1_LO  = CNT_W'(T1_MIN);
   localparam logic [CNT_W-1:0] T1_HI  = CNT_W'(T1_MAX);
   localparam logic [CNT_W-1:0] ST_LO  = CNT_W'(START_MIN);
   localparam logic [CNT_W-1:0] ST_HI  = CNT_W'(START_MAX);
   localparam logic [CNT_W-1:0] RP_LO  = CNT_W'(REP_MIN);
   localparam logic [CNT_W-1:0] RP_HI  = CNT_W'(REP_MAX);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_DATA = 1'b1} state_t;

   function automatic logic in_win(input logic [CNT_W-1:0] c,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
      return (c > lo) && (c < hi);
   endfunction

   function automatic logic inv_ok(input logic [31:0] d);
      return (d[15:8] == ~d[7:0]) && (d[31:24] == ~d[23:16]);
   endfunction

   logic [1:0]       sync_q;
   logic             filt_q;
   logic [FC_W-1:0]  fcnt_q;
   logic [CNT_W-1:0] cnt_q;
   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [NBITS-1:0] sr_q;
   logic             last_ok_q;
   logic             done_q;
   logic             cmd_valid_q;
   logic [NBITS-1:0] cmd_data_q;
   logic             cmd_repeat_q;
   logic             err_pulse_q;
   logic [1:0]       err_code_q;
   logic             overrun_q;

   logic             raw_s;
   logic             edge_s;
   logic             t0_s, t1_s, st_s, rep_s, to_s, last_bit_s;
   logic [NBITS-1:0] sr_d;

   assign raw_s      = sync_q[1] ^ INV_B;
   // The edge is flagged in the cycle the filter is about to flip 0->1.
   assign edge_s     = ~filt_q & raw_s & (fcnt_q == FC_W'(FILT_LEN - 1));
   assign t0_s       = in_win(cnt_q, T0_LO, T0_HI);
   assign t1_s       = in_win(cnt_q, T1_LO, T1_HI);
   assign st_s       = in_win(cnt_q, ST_LO, ST_HI);
   assign rep_s      = in_win(cnt_q, RP_LO, RP_HI);
   assign to_s       = (cnt_q == TO_C);
   assign last_bit_s = (idx_q == IDX_W'(NBITS - 1));

   // Shift register contents with the current bit written at the bit index.
   always_comb begin
      sr_d        = sr_q;
      sr_d[idx_q] = t1_s;
   end

   // Synchroniser, glitch filter and saturating interval counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
         filt_q <= 1'b0;
         fcnt_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], ir_in};
         if (raw_s == filt_q) begin
            fcnt_q <= '0;
         end else if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
            filt_q <= raw_s;
            fcnt_q <= '0;
         end else begin
            fcnt_q <= fcnt_q + FC_W'(1);
         end
         if (!enable || edge_s) begin
            cnt_q <= '0;
         end else if (!to_s) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else begin
            cnt_q <= cnt_q;
         end
      end
   end

   // Frame FSM, pulse outputs and the valid/ack output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         sr_q         <= '0;
         last_ok_q    <= 1'b0;
         done_q       <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_data_q   <= '0;
         cmd_repeat_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_code_q   <= 2'd0;
         overrun_q    <= 1'b0;
      end else begin
         cmd_repeat_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         done_q       <= 1'b0;

         // A completing frame may load in the same cycle the old one is acked.
         if (done_q) begin
            if (!cmd_valid_q || cmd_ack) begin
               cmd_data_q  <= sr_q;
               cmd_valid_q <= 1'b1;
               overrun_q   <= 1'b0;
            end else begin
               overrun_q   <= 1'b1;
            end
         end else if (cmd_valid_q && cmd_ack) begin
            cmd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
         end

         if (!enable) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (edge_s) begin
                     if (st_s) begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                        sr_q    <= '0;
                     end else if (rep_s && last_ok_q) begin
                        cmd_repeat_q <= 1'b1;
                     end
                  end else if (to_s) begin
                     last_ok_q <= 1'b0;
                  end
               end
               S_DATA: begin
                  if (edge_s) begin
                     if (t0_s || t1_s) begin
                        sr_q  <= sr_d;
                        idx_q <= idx_q + IDX_W'(1);
                        if (last_bit_s) begin
                           state_q <= S_IDLE;
                           if ((CHECK_INV != 0) && !inv_ok(32'(sr_d))) begin
                              err_pulse_q <= 1'b1;
                              err_code_q  <= 2'd3;
                              last_ok_q   <= 1'b0;
                           end else begin
                              last_ok_q <= 1'b1;
                              done_q    <= 1'b1;
                           end
                        end
                     end else if (st_s) begin
                        idx_q <= '0;
                        sr_q  <= '0;
                     end else begin
                        state_q     <= S_IDLE;
                        err_pulse_q <= 1'b1;
                        err_code_q  <= 2'd1;
                        last_ok_q   <= 1'b0;
                     end
                  end else if (to_s) begin
                     state_q     <= S_IDLE;
                     err_pulse_q <= 1'b1;
                     err_code_q  <= 2'd2;
                     last_ok_q   <= 1'b0;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_data   = cmd_data_q;
   assign cmd_repeat = cmd_repeat_q;
   assign err_pulse  = err_pulse_q;
   assign err_code   = err_code_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q == S_DATA);

endmodule

// File: tb/tb_ir_decoder_nec.sv
// Directed bench for ir_decoder_nec with timing windows scaled down by 1000
// (leader 335, repeat 280, bit-0 28, bit-1 56, bad 40, timeout 1750 clocks).
module tb_ir_decoder_nec;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        ir_in;
   logic        cmd_ack;
   logic        cmd_valid;
   logic [31:0] cmd_data;
   logic        cmd_repeat;
   logic        err_pulse;
   logic [1:0]  err_code;
   logic        overrun;
   logic        busy;

   int n_err    = 0;
   int n_checks = 0;
   int rep_cnt  = 0;
   int err_cnt  = 0;
   int r0, e0;

   always #5 clk = ~clk;

   ir_decoder_nec #(
      .NBITS(32), .CNT_W(12), .FILT_LEN(4), .INVERT(0), .CHECK_INV(1),
      .T0_MIN(25), .T0_MAX(31), .T1_MIN(50), .T1_MAX(62),
      .START_MIN(310), .START_MAX(360), .REP_MIN(255), .REP_MAX(300),
      .TIMEOUT(1750)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ir_in(ir_in),
      .cmd_ack(cmd_ack), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
      .cmd_repeat(cmd_repeat), .err_pulse(err_pulse), .err_code(err_code),
      .overrun(overrun), .busy(busy)
   );

   // Count the number of cycles each pulse output is high.
   always @(negedge clk) begin
      if (cmd_repeat === 1'b1) rep_cnt++;
      if (err_pulse === 1'b1) err_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Rising edge, then n clocks until the next call's rising edge.
   task automatic ir_bit(input int n);
      ir_in = 1'b1;
      repeat (8) @(negedge clk);
      ir_in = 1'b0;
      repeat (n - 8) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] d, input int bad, input int stop_at,
                             input bit ack_at_done);
      ir_bit(335);
      for (int i = 0; i < 32; i++) begin
         if (i == stop_at) return;
         ir_bit((i == bad) ? 40 : (d[i] ? 56 : 28));
         if (i == bad) break;
      end
      if (ack_at_done) begin
         ir_in = 1'b1;
         repeat (6) @(negedge clk);
         cmd_ack = 1'b1;
         @(negedge clk);
         cmd_ack = 1'b0;
         @(negedge clk);
         ir_in = 1'b0;
         repeat (12) @(negedge clk);
      end else begin
         ir_bit(20);
      end
   endtask

   task automatic do_ack();
      cmd_ack = 1'b1;
      @(negedge clk);
      cmd_ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; ir_in = 1'b0; cmd_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_data", cmd_data, 32'd0);
      chk("rst_repeat", 32'(cmd_repeat), 32'd0);
      chk("rst_err", 32'(err_pulse), 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1; enable = 1'b1;
      repeat (10) @(negedge clk);

      send_frame(32'hF708FB04, -1, 99, 1'b0);
      chk("a_valid", 32'(cmd_valid), 32'd1);
      chk("a_data", cmd_data, 32'hF708FB04);
      chk("a_overrun", 32'(overrun), 32'd0);
      chk("a_busy", 32'(busy), 32'd0);
      chk("a_noerr", 32'(err_cnt), 32'd0);
      repeat (40) @(negedge clk);
      chk("a_hold_valid", 32'(cmd_valid), 32'd1);
      chk("a_hold_data", cmd_data, 32'hF708FB04);
      do_ack();
      chk("a_ack_valid", 32'(cmd_valid), 32'd0);

      r0 = rep_cnt;
      ir_bit(280);
      ir_bit(20);
      chk("rep_pulse", 32'(rep_cnt - r0), 32'd1);
      chk("rep_valid", 32'(cmd_valid), 32'd0);
      chk("rep_data", cmd_data, 32'hF708FB04);

      e0 = err_cnt;
      send_frame(32'hF708FB04, 5, 99, 1'b0);
      chk("bad_pulse", 32'(err_cnt - e0), 32'd1);
      chk("bad_code", 32'(err_code), 32'd1);
      chk("bad_busy", 32'(busy), 32'd0);
      chk("bad_valid", 32'(cmd_valid), 32'd0);

      send_frame(32'h00FF00FF, -1, 99, 1'b0);
      chk("b_valid", 32'(cmd_valid), 32'd1);
      chk("b_data", cmd_data, 32'h00FF00FF);
      chk("b_code_held", 32'(err_code), 32'd1);
      do_ack();
      repeat (1760) @(negedge clk);
      r0 = rep_cnt;
      ir_bit(280);
      ir_bit(20);
      chk("stall_norep", 32'(rep_cnt - r0), 32'd0);

      e0 = err_cnt;
      send_frame(32'hF708FB04, -1, 3, 1'b0);
      chk("to_busy_mid", 32'(busy), 32'd1);
      repeat (1800) @(negedge clk);
      chk("to_pulse", 32'(err_cnt - e0), 32'd1);
      chk("to_code", 32'(err_code), 32'd2);
      chk("to_busy", 32'(busy), 32'd0);

      e0 = err_cnt;
      send_frame(32'hF708FB05, -1, 99, 1'b0);
      chk("inv_pulse", 32'(err_cnt - e0), 32'd1);
      chk("inv_code", 32'(err_code), 32'd3);
      chk("inv_valid", 32'(cmd_valid), 32'd0);

      send_frame(32'hF708FB04, -1, 99, 1'b0);
      chk("ov_first_valid", 32'(cmd_valid), 32'd1);
      send_frame(32'h00FF00FF, -1, 99, 1'b0);
      chk("ov_flag", 32'(overrun), 32'd1);
      chk("ov_data", cmd_data, 32'hF708FB04);
      chk("ov_valid", 32'(cmd_valid), 32'd1);
      do_ack();
      chk("ov_ack_valid", 32'(cmd_valid), 32'd0);
      chk("ov_ack_flag", 32'(overrun), 32'd0);

      send_frame(32'hF708FB04, -1, 99, 1'b0);
      send_frame(32'h00FF00FF, -1, 99, 1'b1);
      chk("co_valid", 32'(cmd_valid), 32'd1);
      chk("co_data", cmd_data, 32'h00FF00FF);
      chk("co_overrun", 32'(overrun), 32'd0);
      do_ack();
      chk("co_ack_valid", 32'(cmd_valid), 32'd0);

      e0 = err_cnt;
      send_frame(32'hF708FB04, -1, 4, 1'b0);
      chk("en_busy_mid", 32'(busy), 32'd1);
      enable = 1'b0;
      @(negedge clk);
      chk("en_busy_off", 32'(busy), 32'd0);
      enable = 1'b1;
      repeat (20) @(negedge clk);
      chk("en_noerr", 32'(err_cnt - e0), 32'd0);

      send_frame(32'hF708FB04, -1, 10, 1'b0);
      chk("mr_busy_mid", 32'(busy), 32'd1);
      e0 = err_cnt;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("mr_valid", 32'(cmd_valid), 32'd0);
      chk("mr_data", cmd_data, 32'd0);
      chk("mr_code", 32'(err_code), 32'd0);
      chk("mr_overrun", 32'(overrun), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_noerr", 32'(err_cnt - e0), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
